answer_checker: RTL and testbench

ANSWER_CHECKER -- requirements
Module: answer_checker

---
 rtl/memtest_pkg.sv | 14 +
 rtl/punch_sync_edge.sv | 26 ++
 rtl/answer_checker.sv | 135 +++++++++++++
 tb/tb_answer_checker.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/memtest_pkg.sv
// Shared types and defaults for the memory-test answer checker.
package memtest_pkg;

  localparam int unsigned MAX_LEN_DEFAULT        = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 250000000;

  typedef enum logic [1:0] {
    StIdle,
    StWaitEntry,
    StWin,
    StLose
  } state_e;

endpackage

// File: rtl/punch_sync_edge.sv
// Two-flop synchronizer for the raw punch button plus rising-edge detect.
module punch_sync_edge (
  input  logic clock,
  input  logic rst,
  input  logic punch_button,
  output logic punch_pulse
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clock) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= punch_button;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Combinational pulse so the FSM acts on the third edge after the button rises.
  assign punch_pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/answer_checker.sv
// Stores a flashed digit sequence, then checks the user's punched answers against it.
module answer_checker
  import memtest_pkg::*;
#(
  parameter int unsigned MAX_LEN        = MAX_LEN_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       seq_wr_en,
  input  logic [3:0] seq_wr_data,
  input  logic       start,
  input  logic       punch_button,
  input  logic [3:0] toggle_answer,
  input  logic       log_out,
  input  logic       result_ack,
  output logic [3:0] seg_in_ans,
  output logic [3:0] entry_count,
  output logic       busy,
  output logic       win,
  output logic       loose
);

  localparam int unsigned PW = $clog2(MAX_LEN + 1);
  localparam int unsigned IW = $clog2(MAX_LEN);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] seq_len_q, seq_len_d;
  logic [IW-1:0] rd_ptr_q, rd_ptr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    seg_q, seg_d;
  logic [3:0]    seq_buf_q [MAX_LEN];
  logic [3:0]    seq_buf_d [MAX_LEN];
  logic          punch;

  punch_sync_edge u_punch_sync_edge (
    .clock        (clock),
    .rst          (rst),
    .punch_button (punch_button),
    .punch_pulse  (punch)
  );

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    seq_len_d = seq_len_q;
    rd_ptr_d  = rd_ptr_q;
    tmo_d     = tmo_q;
    seg_d     = seg_q;
    seq_buf_d = seq_buf_q;

    if (log_out) begin
      state_d  = StIdle;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      tmo_d    = '0;
      seg_d    = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (seq_wr_en && (wr_ptr_q < PW'(MAX_LEN))) begin
            seq_buf_d[wr_ptr_q[IW-1:0]] = seq_wr_data;
            wr_ptr_d                    = wr_ptr_q + PW'(1);
          end
          // Uses wr_ptr_d so a write in the same cycle counts toward the length.
          if (start && (wr_ptr_d != '0)) begin
            state_d   = StWaitEntry;
            seq_len_d = wr_ptr_d;
            rd_ptr_d  = '0;
            tmo_d     = '0;
          end
        end
        StWaitEntry: begin
          if (punch) begin
            seg_d = toggle_answer;
            if (toggle_answer != seq_buf_q[rd_ptr_q]) begin
              state_d = StLose;
            end else if ((PW'(rd_ptr_q) + PW'(1)) == seq_len_q) begin
              state_d = StWin;
            end else begin
              rd_ptr_d = rd_ptr_q + IW'(1);
              tmo_d    = '0;
            end
          end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = StLose;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        StWin, StLose: begin
          if (result_ack) begin
            state_d  = StIdle;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      seq_len_q <= '0;
      rd_ptr_q  <= '0;
      tmo_q     <= '0;
      seg_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      seq_len_q <= seq_len_d;
      rd_ptr_q  <= rd_ptr_d;
      tmo_q     <= tmo_d;
      seg_q     <= seg_d;
    end
  end

  // Buffer contents are only meaningful below wr_ptr, so they need no reset.
  always_ff @(posedge clock) begin
    seq_buf_q <= seq_buf_d;
  end

  always_comb begin
    seg_in_ans  = seg_q;
    entry_count = (state_q == StWin) ? 4'(seq_len_q) : 4'(rd_ptr_q);
    busy        = (state_q == StWaitEntry);
    win         = (state_q == StWin);
    loose       = (state_q == StLose);
  end

endmodule

// File: tb/tb_answer_checker.sv
// Directed bench for answer_checker: vector table plus hand-written corner sequences.
module tb_answer_checker;

  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic       seq_wr_en = 1'b0;
  logic [3:0] seq_wr_data = 4'd0;
  logic       start = 1'b0;
  logic       punch_button = 1'b0;
  logic [3:0] toggle_answer = 4'd0;
  logic       log_out = 1'b0;
  logic       result_ack = 1'b0;
  logic [3:0] seg_in_ans;
  logic [3:0] entry_count;
  logic       busy;
  logic       win;
  logic       loose;

  int n_total = 0;
  int n_pass  = 0;

  answer_checker #(
    .MAX_LEN        (8),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clock         (clock),
    .rst           (rst),
    .seq_wr_en     (seq_wr_en),
    .seq_wr_data   (seq_wr_data),
    .start         (start),
    .punch_button  (punch_button),
    .toggle_answer (toggle_answer),
    .log_out       (log_out),
    .result_ack    (result_ack),
    .seg_in_ans    (seg_in_ans),
    .entry_count   (entry_count),
    .busy          (busy),
    .win           (win),
    .loose         (loose)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [39:0] load;     // digit i in bits [4i+3:4i]
    int          n_load;
    logic [39:0] punches;
    int          n_punch;
    int          exp_win;
    int          exp_loose;
    int          exp_cnt;
    int          exp_seg;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_digit(input logic [3:0] d);
    seq_wr_en   = 1'b1;
    seq_wr_data = d;
    tick();
    seq_wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic punch(input logic [3:0] d);
    toggle_answer = d;
    punch_button  = 1'b1;
    repeat (3) tick();
    punch_button  = 1'b0;
    repeat (2) tick();
  endtask

  task automatic ack();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " win"}, int'(win), 0);
    check({tag, " loose"}, int'(loose), 0);
    check({tag, " seg"}, int'(seg_in_ans), 0);
    check({tag, " cnt"}, int'(entry_count), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [5];
    vec_t v;
    vecs[0] = '{load: 40'h0000000173, n_load: 3, punches: 40'h0000000173, n_punch: 3,
                exp_win: 1, exp_loose: 0, exp_cnt: 3, exp_seg: 1};
    vecs[1] = '{load: 40'h0000000173, n_load: 3, punches: 40'h0000000053, n_punch: 2,
                exp_win: 0, exp_loose: 1, exp_cnt: 1, exp_seg: 5};
    vecs[2] = '{load: 40'h0987654321, n_load: 10, punches: 40'h0087654321, n_punch: 8,
                exp_win: 1, exp_loose: 0, exp_cnt: 8, exp_seg: 8};
    vecs[3] = '{load: 40'h0000000005, n_load: 1, punches: 40'h0000000006, n_punch: 1,
                exp_win: 0, exp_loose: 1, exp_cnt: 0, exp_seg: 6};
    vecs[4] = '{load: 40'h0000000022, n_load: 2, punches: 40'h0000000022, n_punch: 2,
                exp_win: 1, exp_loose: 0, exp_cnt: 2, exp_seg: 2};

    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b1;
    tick();

    for (int k = 0; k < 5; k++) begin
      v = vecs[k];
      for (int i = 0; i < v.n_load; i++) load_digit(v.load[i*4 +: 4]);
      pulse_start();
      check($sformatf("v%0d busy_after_start", k), int'(busy), 1);
      for (int i = 0; i < v.n_punch; i++) begin
        punch(v.punches[i*4 +: 4]);
        if (i < v.n_punch - 1) begin
          check($sformatf("v%0d mid_cnt%0d", k, i), int'(entry_count), i + 1);
        end
      end
      check($sformatf("v%0d win", k), int'(win), v.exp_win);
      check($sformatf("v%0d loose", k), int'(loose), v.exp_loose);
      check($sformatf("v%0d cnt", k), int'(entry_count), v.exp_cnt);
      check($sformatf("v%0d seg", k), int'(seg_in_ans), v.exp_seg);
      check($sformatf("v%0d busy", k), int'(busy), 0);
      ack();
      check($sformatf("v%0d ack_idle", k), int'(win | loose | busy), 0);
    end

    // Punch-to-result latency: result appears right after the third edge.
    load_digit(4'd3);
    pulse_start();
    toggle_answer = 4'd3;
    punch_button  = 1'b1;
    tick();
    check("lat edge1 win", int'(win), 0);
    tick();
    check("lat edge2 win", int'(win), 0);
    tick();
    check("lat edge3 win", int'(win), 1);
    punch_button = 1'b0;
    repeat (2) tick();
    ack();

    // Timeout: loose exactly 20 cycles after entering WAIT_ENTRY.
    load_digit(4'd4);
    pulse_start();
    repeat (19) tick();
    check("tmo 19 loose", int'(loose), 0);
    check("tmo 19 busy", int'(busy), 1);
    tick();
    check("tmo 20 loose", int'(loose), 1);
    ack();

    // Start with an empty buffer stays in IDLE.
    pulse_start();
    check("empty start busy", int'(busy), 0);
    tick();
    check("empty start busy2", int'(busy), 0);

    // Write and start in the same cycle: the write is part of the sequence.
    load_digit(4'd9);
    seq_wr_en   = 1'b1;
    seq_wr_data = 4'd4;
    start       = 1'b1;
    tick();
    seq_wr_en   = 1'b0;
    start       = 1'b0;
    punch(4'd9);
    check("wr+start mid busy", int'(busy), 1);
    punch(4'd4);
    check("wr+start win", int'(win), 1);
    check("wr+start cnt", int'(entry_count), 2);
    ack();

    // log_out during entry clears everything; later punches ignored.
    load_digit(4'd3);
    load_digit(4'd7);
    pulse_start();
    punch(4'd3);
    check("logout pre cnt", int'(entry_count), 1);
    check("logout pre seg", int'(seg_in_ans), 3);
    log_out = 1'b1;
    tick();
    log_out = 1'b0;
    check_all_zero("logout");
    punch(4'd7);
    check_all_zero("logout punch");

    // Reset during entry discards the sequence.
    load_digit(4'd3);
    load_digit(4'd7);
    pulse_start();
    punch(4'd3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_all_zero("rst");
    punch(4'd7);
    check_all_zero("rst punch");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
